// File: rtl/intc_pkg.sv
// ---------------------------------------------------------------------------
// intc_pkg
// Shared definitions for the memory-mapped interrupt controller:
//   - word offsets of the four registers inside the 16-byte window
//     (compared against memAddrBus[3:2])
//   - ICTRL bit positions
//   - delivery FSM state encoding
// ---------------------------------------------------------------------------
package intc_pkg;

  // Word index within the register window (byte offset / 4)
  localparam logic [1:0] REG_IEN   = 2'd0;  // +0  enable mask
  localparam logic [1:0] REG_IPEND = 2'd1;  // +4  pending, write-1-to-clear
  localparam logic [1:0] REG_ICTRL = 2'd2;  // +8  GIE / INSVC
  localparam logic [1:0] REG_IEOI  = 2'd3;  // +12 end of interrupt

  // ICTRL bit positions
  localparam int ICTRL_GIE   = 0;
  localparam int ICTRL_INSVC = 1;

  // Delivery sequencing: one interrupt in flight at a time
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } intcState_t;

  // Width needed to hold a source index (at least one bit)
  function automatic int idxBits(input int numIrq);
    return (numIrq > 1) ? $clog2(numIrq) : 1;
  endfunction

endpackage

// File: rtl/irq_edge_sync.sv
// ---------------------------------------------------------------------------
// irq_edge_sync
// Brings one asynchronous interrupt line into the clk domain and turns its
// rising edge into a single-cycle pulse.
// Ports:
//   clk   in  : system clock
//   reset in  : asynchronous active-low reset
//   irq   in  : raw device interrupt line (asynchronous)
//   rise  out : one-cycle pulse, two edges after irq is first sampled high
// ---------------------------------------------------------------------------
module irq_edge_sync (
  input  logic clk,
  input  logic reset,
  input  logic irq,
  output logic rise
);

  logic syncReg0;
  logic syncReg1;
  logic prevReg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      syncReg0 <= 1'b0;
      syncReg1 <= 1'b0;
      prevReg  <= 1'b0;
    end else begin
      syncReg0 <= irq;
      syncReg1 <= syncReg0;
      prevReg  <= syncReg1;
    end
  end

  // Combinational off the synchronised value so the pending bit can be set
  // on the very next edge.
  assign rise = syncReg1 & ~prevReg;

endmodule

// File: rtl/interrupt_controller.sv
// ---------------------------------------------------------------------------
// interrupt_controller
// Latches rising edges of device interrupt lines as pending and delivers the
// lowest-index enabled pending source to the CPU, sequencing each one through
// request (inta), acknowledge (intAck) and end-of-interrupt (IEOI write).
// Ports:
//   clk        in  : system clock
//   reset      in  : asynchronous active-low reset
//   irq        in  : device interrupt lines, rising-edge sensitive
//   memAddrBus in  : CPU bus address
//   weBus      in  : CPU bus write strobe
//   reBus      in  : CPU bus read strobe
//   dataBusIn  in  : CPU write data
//   dataBusOut out : combinational read data, zero when not selected
//   intAck     in  : one-cycle pulse when the CPU vectors to the handler
//   inta       out : interrupt request to the CPU
//   idn        out : number of the requested source, zero-extended
// ---------------------------------------------------------------------------
module interrupt_controller
  import intc_pkg::*;
#(
  parameter int               DBITS     = 32,
  parameter int               NUM_IRQ   = 4,
  parameter logic [DBITS-1:0] BASE_ADDR = 32'hF0000100
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic [DBITS-1:0]   memAddrBus,
  input  logic               weBus,
  input  logic               reBus,
  input  logic [DBITS-1:0]   dataBusIn,
  output logic [DBITS-1:0]   dataBusOut,
  input  logic               intAck,
  output logic               inta,
  output logic [DBITS-1:0]   idn
);

  localparam int IDX_BITS = idxBits(NUM_IRQ);

  logic [NUM_IRQ-1:0]  riseVec;
  logic [NUM_IRQ-1:0]  ienReg;
  logic [NUM_IRQ-1:0]  pendReg;
  logic [NUM_IRQ-1:0]  pendNext;
  logic [NUM_IRQ-1:0]  activeVec;
  logic [NUM_IRQ-1:0]  swClearMask;
  logic [NUM_IRQ-1:0]  ackMask;
  logic                gieReg;
  intcState_t          stateReg;
  intcState_t          stateNext;
  logic [IDX_BITS-1:0] idnReg;
  logic [IDX_BITS-1:0] idnNext;
  logic [IDX_BITS-1:0] winIdx;
  logic                winValid;
  logic                sel;
  logic [1:0]          regOff;
  logic                wrIen;
  logic                wrPend;
  logic                wrCtrl;
  logic                wrEoi;

  // Byte-lane bits of the address and write data above the implemented
  // register width carry no meaning here.
  logic unusedBits;
  assign unusedBits = ^{memAddrBus[1:0], dataBusIn[DBITS-1:NUM_IRQ]};

  // ---------------------------------------------------------------- capture
  genvar gi;
  generate
    for (gi = 0; gi < NUM_IRQ; gi++) begin : gSync
      irq_edge_sync uSync (
        .clk   (clk),
        .reset (reset),
        .irq   (irq[gi]),
        .rise  (riseVec[gi])
      );
    end
  endgenerate

  // ------------------------------------------------------------- bus decode
  assign sel    = (memAddrBus[DBITS-1:4] == BASE_ADDR[DBITS-1:4]);
  assign regOff = memAddrBus[3:2];
  assign wrIen  = weBus & sel & (regOff == REG_IEN);
  assign wrPend = weBus & sel & (regOff == REG_IPEND);
  assign wrCtrl = weBus & sel & (regOff == REG_ICTRL);
  assign wrEoi  = weBus & sel & (regOff == REG_IEOI);

  // --------------------------------------------------------------- priority
  assign activeVec = pendReg & ienReg;

  // Scan from the top down so the lowest set index is the last one written.
  always_comb begin
    winIdx   = '0;
    winValid = 1'b0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (activeVec[i]) begin
        winIdx   = IDX_BITS'(i);
        winValid = 1'b1;
      end
    end
  end

  // ------------------------------------------------------------------- FSM
  always_comb begin
    stateNext = stateReg;
    idnNext   = idnReg;
    ackMask   = '0;
    case (stateReg)
      IDLE: begin
        if (gieReg && winValid) begin
          stateNext = REQ;
          idnNext   = winIdx;
        end
      end
      // Once requested the interrupt is committed: only intAck moves on,
      // regardless of later mask, GIE or pending changes.
      REQ: begin
        if (intAck) begin
          stateNext       = SERVICE;
          ackMask[idnReg] = 1'b1;
        end
      end
      SERVICE: begin
        if (wrEoi) begin
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // A new edge is OR-ed in last so it survives both a software clear and
  // the dispatch clear landing on the same bit.
  assign swClearMask = wrPend ? dataBusIn[NUM_IRQ-1:0] : '0;
  assign pendNext    = (pendReg & ~swClearMask & ~ackMask) | riseVec;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stateReg <= IDLE;
      idnReg   <= '0;
      ienReg   <= '0;
      pendReg  <= '0;
      gieReg   <= 1'b0;
    end else begin
      stateReg <= stateNext;
      idnReg   <= idnNext;
      pendReg  <= pendNext;
      if (wrIen) begin
        ienReg <= dataBusIn[NUM_IRQ-1:0];
      end
      if (wrCtrl) begin
        gieReg <= dataBusIn[ICTRL_GIE];
      end
    end
  end

  // --------------------------------------------------------------- outputs
  assign inta = (stateReg == REQ);
  assign idn  = {{(DBITS - IDX_BITS){1'b0}}, idnReg};

  // Reads are combinational: the CPU samples data in the strobe cycle.
  always_comb begin
    dataBusOut = '0;
    if (reBus && sel) begin
      case (regOff)
        REG_IEN:   dataBusOut[NUM_IRQ-1:0] = ienReg;
        REG_IPEND: dataBusOut[NUM_IRQ-1:0] = pendReg;
        REG_ICTRL: begin
          dataBusOut[ICTRL_GIE]   = gieReg;
          dataBusOut[ICTRL_INSVC] = (stateReg == SERVICE);
        end
        default:   dataBusOut = '0;
      endcase
    end
  end

endmodule
